// File: rtl/bcd_pkg.sv
// ============================================================================
//  Module   : bcd_pkg
//  Brief    : Shared FSM states and digit constants for the binary-to-BCD converter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Number of decimal digits needed to show the largest WIDTH-bit value.
    function automatic int bcd_digits_needed(input int width);
        logic [63:0] v;
        int          n;
        v = (64'd1 << width) - 64'd1;
        n = 0;
        do begin
            v = v / 64'd10;
            n++;
        end while (v != 64'd0);
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_add3.sv
// ============================================================================
//  Module   : bcd_add3
//  Brief    : Double-dabble digit correction: add 3 to a digit of 5 or more.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_add3
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? (i_digit + BCD_ADJ_ADD) : i_digit;

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
//  Module   : bin2bcd_seq
//  Brief    : Sequential double-dabble converter, one bit per clock, with a
//             registered BCD result and leading-zero blanking mask.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  I_CLK,
    input  logic                  I_RST,
    input  logic                  I_START,
    input  logic [WIDTH-1:0]      I_BIN,
    output logic                  O_BUSY,
    output logic                  O_DONE,
    output logic [4*DIGITS-1:0]   O_BCD,
    output logic [DIGITS-1:0]     O_BLANK
);

    localparam int               CNT_W       = $clog2(WIDTH + 1);
    localparam int               SW          = 4 * DIGITS;
    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(WIDTH - 1);
    localparam logic [DIGITS-1:0] c_blank_rst = {DIGITS{1'b1}} << 1;

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("bin2bcd_seq: WIDTH must be in 2..32");
        end
        if (DIGITS < bcd_digits_needed(WIDTH)) begin : g_bad_digits
            $error("bin2bcd_seq: DIGITS too small to hold 2^WIDTH-1");
        end
    endgenerate

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_shift;
    logic [SW-1:0]     r_scratch;

    logic [SW-1:0]     w_adj;
    logic [SW-1:0]     w_step;
    logic [DIGITS-1:0] w_blank;
    logic              w_zero;
    logic              w_unused_msb;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_add3 u_add3 (
                .i_digit (r_scratch[4*g +: 4]),
                .o_digit (w_adj[4*g +: 4])
            );
        end
    endgenerate

    // The top digit never exceeds 4 before adjustment when DIGITS is sized
    // correctly, so its shifted-out MSB is always zero.
    assign w_unused_msb = w_adj[SW-1];
    assign w_step       = {w_adj[SW-2:0], r_shift[WIDTH-1]};

    always_comb begin
        w_blank = '0;
        w_zero  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero     = w_zero & (w_step[4*i +: 4] == 4'd0);
            w_blank[i] = w_zero;
        end
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_scratch <= '0;
            O_BUSY    <= 1'b0;
            O_DONE    <= 1'b0;
            O_BCD     <= '0;
            O_BLANK   <= c_blank_rst;
        end else begin
            case (r_state)
                IDLE: begin
                    O_DONE <= 1'b0;
                    if (I_START) begin
                        r_shift   <= I_BIN;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        O_BUSY    <= 1'b1;
                        r_state   <= CONV;
                    end
                end
                CONV: begin
                    r_scratch <= w_step;
                    r_shift   <= r_shift << 1;
                    if (r_cnt == c_cnt_last) begin
                        O_BCD   <= w_step;
                        O_BLANK <= w_blank;
                        O_DONE  <= 1'b1;
                        O_BUSY  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    O_DONE <= 1'b0;
                    if (I_START) begin
                        r_shift   <= I_BIN;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        O_BUSY    <= 1'b1;
                        r_state   <= CONV;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
